// File: rtl/window_gen_3x3.sv
// 3x3 sliding-window generator: two line buffers plus a 3x3 register window over a raster pixel stream.
// Optional macro WINGEN_COORD_EN adds registered centre-coordinate outputs win_row/win_col.
module window_gen_3x3 #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          pix_in,
    input  logic                       pix_valid,
    input  logic                       sof,
    output logic [DATA_W-1:0]          p1,
    output logic [DATA_W-1:0]          p2,
    output logic [DATA_W-1:0]          p3,
    output logic [DATA_W-1:0]          p4,
    output logic [DATA_W-1:0]          p5,
    output logic [DATA_W-1:0]          p6,
    output logic [DATA_W-1:0]          p7,
    output logic [DATA_W-1:0]          p8,
    output logic [DATA_W-1:0]          p9,
    output logic                       win_valid,
`ifdef WINGEN_COORD_EN
    output logic [$clog2(IMG_H)-1:0]   win_row,
    output logic [$clog2(IMG_W)-1:0]   win_col,
`endif
    output logic                       frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    logic [DATA_W-1:0]   win_q [9];
    logic [DATA_W-1:0]   win_d [9];
    logic                win_valid_q, win_valid_d;
    logic                frame_done_q, frame_done_d;
    logic [DATA_W-1:0]   lb0_q [IMG_W];
    logic [DATA_W-1:0]   lb1_q [IMG_W];

    logic                accept;
    logic                restart;
    logic                last_pix;
    logic                centre_ok;
    logic [CW-1:0]       eff_col;
    logic [RW-1:0]       eff_row;
    logic [DATA_W-1:0]   top;
    logic [DATA_W-1:0]   mid;

`ifdef WINGEN_COORD_EN
    logic [RW-1:0]       win_row_q, win_row_d;
    logic [CW-1:0]       win_col_q, win_col_d;
`endif

    // A sof pixel is always (0,0), whether it opens a frame or aborts one in flight.
    always_comb begin
        restart   = pix_valid & sof;
        accept    = pix_valid & (sof | (state_q == RUN));
        eff_col   = restart ? '0 : col_q;
        eff_row   = restart ? '0 : row_q;
        top       = lb1_q[eff_col];
        mid       = lb0_q[eff_col];
        last_pix  = (eff_row == RW'(IMG_H - 1)) && (eff_col == CW'(IMG_W - 1));
        centre_ok = (eff_row >= RW'(2)) && (eff_col >= CW'(2));

        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;
`ifdef WINGEN_COORD_EN
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
`endif

        if (accept) begin
            state_d = RUN;
            for (int r = 0; r < 3; r++) begin
                win_d[3*r]     = win_q[3*r + 1];
                win_d[3*r + 1] = win_q[3*r + 2];
            end
            win_d[2]    = top;
            win_d[5]    = mid;
            win_d[8]    = pix_in;
            win_valid_d = centre_ok;
`ifdef WINGEN_COORD_EN
            if (centre_ok) begin
                win_row_d = eff_row - RW'(1);
                win_col_d = eff_col - CW'(1);
            end
`endif
            if (last_pix) begin
                state_d      = IDLE;
                col_d        = '0;
                row_d        = '0;
                frame_done_d = 1'b1;
            end else if (eff_col == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = eff_row + RW'(1);
            end else begin
                col_d = eff_col + CW'(1);
                row_d = eff_row;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 9; i++) win_q[i] <= '0;
`ifdef WINGEN_COORD_EN
            win_row_q    <= '0;
            win_col_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            win_q        <= win_d;
`ifdef WINGEN_COORD_EN
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
`endif
        end
    end

    // Line buffers carry no reset; stale contents only reach the window in rows 0-1 or columns 0-1.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[eff_col] <= mid;
            lb0_q[eff_col] <= pix_in;
        end
    end

    assign p1         = win_q[0];
    assign p2         = win_q[1];
    assign p3         = win_q[2];
    assign p4         = win_q[3];
    assign p5         = win_q[4];
    assign p6         = win_q[5];
    assign p7         = win_q[6];
    assign p8         = win_q[7];
    assign p9         = win_q[8];
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;
`ifdef WINGEN_COORD_EN
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
`endif

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3 on a 4x4 image with pixel value 16*row+col (+offset).
module tb_window_gen_3x3;
    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] pix_in = '0;
    logic          pix_valid = 1'b0;
    logic          sof = 1'b0;
    logic [DW-1:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
    logic          win_valid, frame_done;
`ifdef WINGEN_COORD_EN
    logic [1:0]    win_row, win_col;
`endif

    window_gen_3x3 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
        .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7), .p8(p8), .p9(p9),
        .win_valid(win_valid),
`ifdef WINGEN_COORD_EN
        .win_row(win_row), .win_col(win_col),
`endif
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [71:0] wins [$];
    logic [3:0]  coords [$];
    int          fd_cnt;
    int          fd_idx;
    logic        fd_with_wv;
    int          bubble_viol;

    function automatic logic [71:0] cur_win();
        return {p1, p2, p3, p4, p5, p6, p7, p8, p9};
    endfunction

    // Expected window for the k-th window of a frame (centres in raster order).
    function automatic logic [71:0] exp_win(input int off, input int k);
        logic [71:0] w = '0;
        int r = 1 + k / 2;
        int c = 1 + k % 2;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                w = (w << 8) | 72'(off + 16 * (r + dr) + (c + dc));
        return w;
    endfunction

    task automatic clear_log();
        wins.delete();
        coords.delete();
        fd_cnt = 0;
        fd_idx = -1;
        fd_with_wv = 1'b0;
        bubble_viol = 0;
    endtask

    task automatic step(input logic v, input logic s, input logic r, input logic [DW-1:0] px);
        pix_valid = v;
        sof = s;
        rst = r;
        pix_in = px;
        @(posedge clk);
        #1;
        if (win_valid) begin
            wins.push_back(cur_win());
`ifdef WINGEN_COORD_EN
            coords.push_back({win_row, win_col});
`endif
            if (!v) bubble_viol++;
        end
        if (frame_done) begin
            fd_cnt++;
            fd_idx = wins.size();
            fd_with_wv = win_valid;
        end
    endtask

    task automatic send_frame(input int off, input bit bubbles, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            step(1'b1, i == 0, 1'b0, DW'(off + 16 * (i / W) + (i % W)));
            if (bubbles) begin
                step(1'b0, 1'b0, 1'b0, 8'hEE);
                step(1'b0, 1'b0, 1'b0, 8'hDD);
            end
        end
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1, 8'hFF);
        step(1'b1, 1'b1, 1'b1, 8'hFF);
        checks++;
        if (cur_win() !== 72'h0) begin
            errors++; $display("FAIL reset_window got %h want 0", cur_win());
        end
        checks++;
        if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
            errors++; $display("FAIL reset_flags got wv=%b fd=%b want 0 0", win_valid, frame_done);
        end
        step(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_basic();
        clear_log();
        send_frame(0, 1'b0, 0, 15);
        checks++;
        if (wins.size() != 4) begin
            errors++; $display("FAIL basic_count got %0d want 4", wins.size());
        end
        for (int k = 0; k < 4 && k < wins.size(); k++) begin
            checks++;
            if (wins[k] !== exp_win(0, k)) begin
                errors++; $display("FAIL basic_win%0d got %h want %h", k, wins[k], exp_win(0, k));
            end
`ifdef WINGEN_COORD_EN
            checks++;
            if (coords[k] !== {2'(1 + k / 2), 2'(1 + k % 2)}) begin
                errors++; $display("FAIL basic_coord%0d got %h want %h", k, coords[k], {2'(1 + k / 2), 2'(1 + k % 2)});
            end
`endif
        end
        checks++;
        if (fd_cnt != 1 || fd_idx != 4 || fd_with_wv !== 1'b1) begin
            errors++; $display("FAIL basic_frame_done got cnt=%0d idx=%0d wv=%b want 1 4 1", fd_cnt, fd_idx, fd_with_wv);
        end
    endtask

    task automatic test_bubbles();
        clear_log();
        send_frame(0, 1'b1, 0, 15);
        checks++;
        if (wins.size() != 4) begin
            errors++; $display("FAIL bubble_count got %0d want 4", wins.size());
        end
        for (int k = 0; k < 4 && k < wins.size(); k++) begin
            checks++;
            if (wins[k] !== exp_win(0, k)) begin
                errors++; $display("FAIL bubble_win%0d got %h want %h", k, wins[k], exp_win(0, k));
            end
        end
        checks++;
        if (bubble_viol != 0 || fd_cnt != 1) begin
            errors++; $display("FAIL bubble_gating got viol=%0d fd=%0d want 0 1", bubble_viol, fd_cnt);
        end
    endtask

    task automatic test_idle_filter();
        logic [71:0] snap;
        clear_log();
        snap = cur_win();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, DW'(8'h40 + i));
            checks++;
            if (win_valid !== 1'b0 || cur_win() !== snap) begin
                errors++; $display("FAIL idle_hold%0d got wv=%b win=%h want 0 %h", i, win_valid, cur_win(), snap);
            end
        end
        send_frame(0, 1'b0, 0, 15);
        checks++;
        if (wins.size() != 4 || fd_cnt != 1) begin
            errors++; $display("FAIL idle_frame_count got wins=%0d fd=%0d want 4 1", wins.size(), fd_cnt);
        end
        for (int k = 0; k < 4 && k < wins.size(); k++) begin
            checks++;
            if (wins[k] !== exp_win(0, k)) begin
                errors++; $display("FAIL idle_win%0d got %h want %h", k, wins[k], exp_win(0, k));
            end
        end
    endtask

    task automatic test_restart();
        clear_log();
        for (int i = 0; i <= 8; i++)
            step(1'b1, i == 0, 1'b0, DW'(16 * (i / W) + (i % W)));
        send_frame(8'h80, 1'b0, 0, 15);
        checks++;
        if (wins.size() != 4 || fd_cnt != 1) begin
            errors++; $display("FAIL restart_count got wins=%0d fd=%0d want 4 1", wins.size(), fd_cnt);
        end
        for (int k = 0; k < 4 && k < wins.size(); k++) begin
            checks++;
            if (wins[k] !== exp_win(8'h80, k)) begin
                errors++; $display("FAIL restart_win%0d got %h want %h", k, wins[k], exp_win(8'h80, k));
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_log();
        for (int i = 0; i <= 10; i++)
            step(1'b1, i == 0, 1'b0, DW'(16 * (i / W) + (i % W)));
        step(1'b0, 1'b0, 1'b1, '0);
        checks++;
        if (cur_win() !== 72'h0 || win_valid !== 1'b0 || frame_done !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs got win=%h wv=%b fd=%b want 0 0 0", cur_win(), win_valid, frame_done);
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h55);
        checks++;
        if (cur_win() !== 72'h0) begin
            errors++; $display("FAIL midrst_needs_sof got %h want 0", cur_win());
        end
        clear_log();
        send_frame(0, 1'b0, 0, 15);
        checks++;
        if (wins.size() != 4 || fd_cnt != 1) begin
            errors++; $display("FAIL midrst_count got wins=%0d fd=%0d want 4 1", wins.size(), fd_cnt);
        end
        for (int k = 0; k < 4 && k < wins.size(); k++) begin
            checks++;
            if (wins[k] !== exp_win(0, k)) begin
                errors++; $display("FAIL midrst_win%0d got %h want %h", k, wins[k], exp_win(0, k));
            end
        end
    endtask

    initial begin
        clear_log();
        test_reset();
        test_basic();
        test_bubbles();
        test_idle_filter();
        test_restart();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
